// File: rtl/counter_updown_n.sv
// Parametrised up/down counter with load, terminal-count decode, wrap pulse and sticky overflow.
// Define COUNTER_SAT_EN to build the saturating variant instead of the default wrap-around one.
module counter_updown_n #(
   parameter int               WIDTH     = 8,
   parameter logic [WIDTH-1:0] MAX_VAL   = {WIDTH{1'b1}},
   parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             en,
   input  logic             up_dn,
   input  logic             load,
   input  logic [WIDTH-1:0] load_val,
   input  logic             clr_ovf,
   output logic [WIDTH-1:0] count,
   output logic             tc,
   output logic             wrap,
   output logic             ovf
);

   logic [WIDTH-1:0] load_eff;
   logic [WIDTH-1:0] next_count;
   logic             at_limit;
   logic             next_wrap;
   logic             next_ovf;

   // Out-of-range load values are clamped so the count never leaves 0..MAX_VAL.
   assign load_eff = (load_val > MAX_VAL) ? MAX_VAL : load_val;
   assign at_limit = up_dn ? (count == MAX_VAL) : (count == '0);
   assign tc       = at_limit;

   // A step attempted at the limit sets ovf even if clr_ovf is high in the same cycle.
   always_comb begin
      next_count = count;
      next_wrap  = 1'b0;
      next_ovf   = clr_ovf ? 1'b0 : ovf;
      if (load) begin
         next_count = load_eff;
      end else if (en) begin
         if (at_limit) begin
`ifdef COUNTER_SAT_EN
            next_ovf   = 1'b1;
`else
            next_count = up_dn ? '0 : MAX_VAL;
            next_wrap  = 1'b1;
            next_ovf   = 1'b1;
`endif
         end else begin
            next_count = up_dn ? (count + 1'b1) : (count - 1'b1);
         end
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         count <= RESET_VAL;
         wrap  <= 1'b0;
         ovf   <= 1'b0;
      end else begin
         count <= next_count;
         wrap  <= next_wrap;
         ovf   <= next_ovf;
      end
   end

endmodule

// File: tb/tb_counter_updown_n.sv
// Directed bench for counter_updown_n in its default wrap-around build, using three
// instances: full 8-bit range, modulus 10, and a non-zero reset value.
module tb_counter_updown_n;

   logic       clk;
   logic       en;
   logic       up_dn;
   logic       load;
   logic       clr_ovf;
   logic       reset_a;
   logic       reset_b;
   logic       reset_c;
   logic [7:0] load_val;
   logic [3:0] load_val_b;

   logic [7:0] count_a;
   logic       tc_a;
   logic       wrap_a;
   logic       ovf_a;
   logic [3:0] count_b;
   logic       tc_b;
   logic       wrap_b;
   logic       ovf_b;
   logic [7:0] count_c;
   logic       tc_c;
   logic       wrap_c;
   logic       ovf_c;

   int checks = 0;
   int errors = 0;

   counter_updown_n #(.WIDTH(8)) dut_a (
      .clk(clk), .reset(reset_a), .en(en), .up_dn(up_dn), .load(load),
      .load_val(load_val), .clr_ovf(clr_ovf),
      .count(count_a), .tc(tc_a), .wrap(wrap_a), .ovf(ovf_a)
   );

   counter_updown_n #(.WIDTH(4), .MAX_VAL(4'd9)) dut_b (
      .clk(clk), .reset(reset_b), .en(en), .up_dn(up_dn), .load(load),
      .load_val(load_val_b), .clr_ovf(clr_ovf),
      .count(count_b), .tc(tc_b), .wrap(wrap_b), .ovf(ovf_b)
   );

   counter_updown_n #(.WIDTH(8), .RESET_VAL(8'd5)) dut_c (
      .clk(clk), .reset(reset_c), .en(en), .up_dn(up_dn), .load(load),
      .load_val(load_val), .clr_ovf(clr_ovf),
      .count(count_c), .tc(tc_c), .wrap(wrap_c), .ovf(ovf_c)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Advance one rising edge and settle just after it.
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("[TB] FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   initial begin
      en = 0; up_dn = 1; load = 0; clr_ovf = 0;
      reset_a = 1; reset_b = 1; reset_c = 1;
      load_val = 8'd0; load_val_b = 4'd0;
      step();
      step();

      chk("a_rst_count", count_a, 0);
      chk("a_rst_wrap", wrap_a, 0);
      chk("a_rst_ovf", ovf_a, 0);
      chk("a_rst_tc_up", tc_a, 0);
      chk("c_rst_count", count_c, 5);

      // Full-range instance counting up and wrapping.
      reset_a = 0; en = 1; up_dn = 1;
      step();
      chk("a_up_1", count_a, 1);
      step();
      chk("a_up_2", count_a, 2);

      load = 1; load_val = 8'd200;
      step();
      chk("a_load200_no_step", count_a, 200);
      load_val = 8'd254;
      step();
      chk("a_load254", count_a, 254);
      load = 0;
      step();
      chk("a_255", count_a, 255);
      chk("a_tc_at_255", tc_a, 1);
      chk("a_no_wrap_yet", wrap_a, 0);
      step();
      chk("a_wrap_count", count_a, 0);
      chk("a_wrap_pulse", wrap_a, 1);
      chk("a_ovf_set", ovf_a, 1);
      chk("a_tc_after_wrap", tc_a, 0);
      step();
      chk("a_after_wrap_count", count_a, 1);
      chk("a_wrap_one_cycle", wrap_a, 0);
      chk("a_ovf_sticky", ovf_a, 1);

      // Hold with enable low.
      en = 0; load = 1; load_val = 8'd42;
      step();
      load = 0;
      for (int i = 0; i < 5; i++) step();
      chk("a_hold_count", count_a, 42);
      chk("a_hold_wrap", wrap_a, 0);
      chk("a_hold_ovf", ovf_a, 1);

      clr_ovf = 1;
      step();
      clr_ovf = 0;
      chk("a_clr_ovf", ovf_a, 0);
      chk("a_clr_count", count_a, 42);

      // Clear and wrap on the same edge: wrap wins.
      load = 1; load_val = 8'd255;
      step();
      load = 0; en = 1; clr_ovf = 1;
      step();
      chk("a_clrwrap_count", count_a, 0);
      chk("a_clrwrap_wrap", wrap_a, 1);
      chk("a_clrwrap_ovf", ovf_a, 1);
      en = 0;
      step();
      clr_ovf = 0;
      chk("a_clr_after", ovf_a, 0);
      chk("a_clr_after_wrap", wrap_a, 0);

      // Down direction from zero.
      up_dn = 0;
      #1;
      chk("a_tc_down_at_0", tc_a, 1);
      en = 1;
      step();
      chk("a_down_wrap_count", count_a, 255);
      chk("a_down_wrap_pulse", wrap_a, 1);
      chk("a_down_ovf", ovf_a, 1);
      step();
      chk("a_down_254", count_a, 254);
      chk("a_down_wrap_gone", wrap_a, 0);

      // Modulus-10 instance.
      reset_a = 1; reset_b = 0; en = 0; up_dn = 1;
      load = 1; load_val_b = 4'd8;
      step();
      load = 0;
      chk("b_load8", count_b, 8);
      en = 1;
      step();
      chk("b_9", count_b, 9);
      chk("b_tc_at_9", tc_b, 1);
      step();
      chk("b_wrap_count", count_b, 0);
      chk("b_wrap_pulse", wrap_b, 1);
      chk("b_ovf", ovf_b, 1);
      up_dn = 0;
      #1;
      chk("b_tc_down_at_0", tc_b, 1);
      step();
      chk("b_down_wrap_count", count_b, 9);
      chk("b_down_wrap_pulse", wrap_b, 1);
      step();
      chk("b_down_8", count_b, 8);
      load = 1; load_val_b = 4'd15;
      step();
      load = 0;
      chk("b_load_clamp", count_b, 9);
      chk("b_load_no_wrap", wrap_b, 0);

      // Non-zero reset value and mid-run reset.
      reset_b = 1; reset_c = 0; en = 1; up_dn = 1;
      step();
      chk("c_up_6", count_c, 6);
      step();
      chk("c_up_7", count_c, 7);
      load = 1; load_val = 8'd255;
      step();
      load = 0;
      step();
      chk("c_wrap_count", count_c, 0);
      chk("c_wrap_pulse", wrap_c, 1);
      chk("c_ovf", ovf_c, 1);
      reset_c = 1; load = 1; load_val = 8'd100; en = 1;
      step();
      load = 0;
      chk("c_midreset_count", count_c, 5);
      chk("c_midreset_wrap", wrap_c, 0);
      chk("c_midreset_ovf", ovf_c, 0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
